// File: rtl/auction_pkg.sv
// Shared types and sizing helpers for the sealed-bid auction sequencer.
package auction_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_RESOLVE = 2'd2,
        S_RESULT  = 2'd3
    } state_t;

    localparam int unsigned LOG2_BIDDERS_DEF = 2;
    localparam int unsigned BID_W_DEF        = 2;

    function automatic int unsigned num_bidders(input int unsigned log2_n);
        return 32'(1) << log2_n;
    endfunction

endpackage

// File: rtl/auction_max_update.sv
// Running max / leader tracker; with AUCTION_SECOND_PRICE_EN it also keeps the
// runner-up bid and reports it as the clearing price.
module auction_max_update
    import auction_pkg::*;
#(
    parameter int unsigned N = LOG2_BIDDERS_DEF,
    parameter int unsigned W = BID_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_upd,
    input  logic [N-1:0] i_id,
    input  logic [W-1:0] i_value,
    output logic [W-1:0] o_max,
    output logic [N-1:0] o_leader,
    output logic         o_have_bid,
    output logic [W-1:0] o_price
);

    logic [W-1:0] r_max;
    logic [N-1:0] r_leader;
    logic         r_have_bid;

    // Strict compare: a tie leaves the earlier-accepted bidder in the lead.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_max      <= '0;
            r_leader   <= '0;
            r_have_bid <= 1'b0;
        end else if (i_upd && (!r_have_bid || (i_value > r_max))) begin
            r_max      <= i_value;
            r_leader   <= i_id;
            r_have_bid <= 1'b1;
        end
    end

`ifdef AUCTION_SECOND_PRICE_EN
    logic [W-1:0] r_second;

    // Displaced leader drops to second; a bid equal to max also raises second.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_second <= '0;
        end else if (i_upd && r_have_bid) begin
            if (i_value > r_max) begin
                r_second <= r_max;
            end else if (i_value > r_second) begin
                r_second <= i_value;
            end
        end
    end

    assign o_price = r_second;
`else
    assign o_price = r_max;
`endif

    assign o_max      = r_max;
    assign o_leader   = r_leader;
    assign o_have_bid = r_have_bid;

endmodule

// File: rtl/auction_seq.sv
// Sealed-bid auction sequencer: collects one bid per bidder, resolves the
// winner and presents a held result. Optional macro: AUCTION_SECOND_PRICE_EN.
module auction_seq
    import auction_pkg::*;
#(
    parameter int unsigned N = LOG2_BIDDERS_DEF,
    parameter int unsigned W = BID_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         bid_valid,
    output logic         bid_ready,
    input  logic [N-1:0] bid_id,
    input  logic [W-1:0] bid_value,
    input  logic         close,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [N-1:0] winner,
    output logic [W-1:0] winning_bid,
    output logic [W-1:0] price,
    output logic         no_bids,
    output logic         dup_err
);

    localparam int unsigned NB = num_bidders(N);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [NB-1:0] r_seen;
    logic [NB-1:0] w_bid_onehot;
    logic [NB-1:0] w_seen_upd;
    logic          w_accept;
    logic          w_is_dup;
    logic          w_new_bid;
    logic          w_clear;

    logic          r_bid_ready;
    logic          r_result_valid;
    logic [N-1:0]  r_winner;
    logic [W-1:0]  r_winning_bid;
    logic [W-1:0]  r_price;
    logic          r_no_bids;
    logic          r_dup_err;

    logic [W-1:0]  w_max;
    logic [N-1:0]  w_leader;
    logic          w_have_bid;
    logic [W-1:0]  w_price;

    assign w_accept     = bid_valid && (r_state == S_COLLECT);
    assign w_is_dup     = r_seen[bid_id];
    assign w_new_bid    = w_accept && !w_is_dup;
    assign w_bid_onehot = NB'(1) << bid_id;
    assign w_seen_upd   = r_seen | w_bid_onehot;
    assign w_clear      = (r_state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_COLLECT;
            S_COLLECT: if (close || (w_new_bid && (&w_seen_upd))) w_state_nxt = S_RESOLVE;
            S_RESOLVE: w_state_nxt = S_RESULT;
            S_RESULT:  if (result_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_seen <= '0;
        end else if (w_new_bid) begin
            r_seen <= w_seen_upd;
        end
    end

    auction_max_update #(
        .N (N),
        .W (W)
    ) u_max_update (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (w_clear),
        .i_upd      (w_new_bid),
        .i_id       (bid_id),
        .i_value    (bid_value),
        .o_max      (w_max),
        .o_leader   (w_leader),
        .o_have_bid (w_have_bid),
        .o_price    (w_price)
    );

    // Handshake flags follow the next state; result fields latch once in RESOLVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bid_ready    <= 1'b0;
            r_result_valid <= 1'b0;
            r_dup_err      <= 1'b0;
            r_winner       <= '0;
            r_winning_bid  <= '0;
            r_price        <= '0;
            r_no_bids      <= 1'b0;
        end else begin
            r_bid_ready    <= (w_state_nxt == S_COLLECT);
            r_result_valid <= (w_state_nxt == S_RESULT);
            r_dup_err      <= w_accept && w_is_dup;
            if (r_state == S_RESOLVE) begin
                r_winner      <= w_have_bid ? w_leader : '0;
                r_winning_bid <= w_have_bid ? w_max    : '0;
                r_price       <= w_have_bid ? w_price  : '0;
                r_no_bids     <= !w_have_bid;
            end
        end
    end

    assign bid_ready    = r_bid_ready;
    assign result_valid = r_result_valid;
    assign winner       = r_winner;
    assign winning_bid  = r_winning_bid;
    assign price        = r_price;
    assign no_bids      = r_no_bids;
    assign dup_err      = r_dup_err;

endmodule

// File: tb/tb_auction_seq.sv
// Directed self-checking bench for auction_seq (N=2, W=4), both price builds.
module tb_auction_seq;

    localparam int unsigned N = 2;
    localparam int unsigned W = 4;

`ifdef AUCTION_SECOND_PRICE_EN
    localparam bit SECOND_PRICE = 1'b1;
`else
    localparam bit SECOND_PRICE = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         bid_valid;
    logic         bid_ready;
    logic [N-1:0] bid_id;
    logic [W-1:0] bid_value;
    logic         close;
    logic         result_valid;
    logic         result_ready;
    logic [N-1:0] winner;
    logic [W-1:0] winning_bid;
    logic [W-1:0] price;
    logic         no_bids;
    logic         dup_err;

    int n_checks = 0;
    int n_errors = 0;

    auction_seq #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bid_valid    (bid_valid),
        .bid_ready    (bid_ready),
        .bid_id       (bid_id),
        .bid_value    (bid_value),
        .close        (close),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .winner       (winner),
        .winning_bid  (winning_bid),
        .price        (price),
        .no_bids      (no_bids),
        .dup_err      (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_auction();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bid_ready_after_start", int'(bid_ready), 1);
    endtask

    task automatic send_bid(input int id, input int val, input bit with_close);
        bid_valid = 1'b1;
        bid_id    = N'(id);
        bid_value = W'(val);
        close     = with_close;
        tick();
        bid_valid = 1'b0;
        close     = 1'b0;
    endtask

    task automatic do_close();
        close = 1'b1;
        tick();
        close = 1'b0;
    endtask

    task automatic check_result(input string tag, input int exp_win, input int exp_bid,
                                input int exp_price, input int exp_nob);
        chk({tag, "_valid"},  int'(result_valid), 1);
        chk({tag, "_winner"}, int'(winner), exp_win);
        chk({tag, "_bid"},    int'(winning_bid), exp_bid);
        chk({tag, "_price"},  int'(price), exp_price);
        chk({tag, "_nobids"}, int'(no_bids), exp_nob);
    endtask

    task automatic handshake(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, "_valid_drop"}, int'(result_valid), 0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bid_valid    = 1'b0;
        bid_id       = '0;
        bid_value    = '0;
        close        = 1'b0;
        result_ready = 1'b0;
        tick();
        tick();
        chk("rst_bid_ready", int'(bid_ready), 0);
        chk("rst_result_valid", int'(result_valid), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_winning_bid", int'(winning_bid), 0);
        chk("rst_price", int'(price), 0);
        chk("rst_no_bids", int'(no_bids), 0);
        chk("rst_dup_err", int'(dup_err), 0);
        rst = 1'b0;
        tick();

        // All four bidders -> auto-close, then a held result
        open_auction();
        send_bid(0, 5, 1'b0);
        send_bid(1, 9, 1'b0);
        send_bid(2, 3, 1'b0);
        send_bid(3, 7, 1'b0);
        chk("auto_bid_ready", int'(bid_ready), 0);
        chk("auto_resolve_valid", int'(result_valid), 0);
        tick();
        check_result("auto", 1, 9, SECOND_PRICE ? 7 : 9, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", int'(result_valid), 1);
            chk("hold_winner", int'(winner), 1);
            chk("hold_bid", int'(winning_bid), 9);
        end
        start = 1'b1;
        handshake("auto");
        start = 1'b0;
        tick();
        chk("start_in_handshake_ignored", int'(bid_ready), 0);

        // Tie keeps first bidder
        open_auction();
        send_bid(2, 6, 1'b0);
        send_bid(0, 6, 1'b0);
        do_close();
        chk("tie_resolve_valid", int'(result_valid), 0);
        tick();
        check_result("tie", 2, 6, 6, 0);
        handshake("tie");

        // No bids
        open_auction();
        do_close();
        chk("nobid_resolve_valid", int'(result_valid), 0);
        tick();
        check_result("nobid", 0, 0, 0, 1);
        handshake("nobid");

        // Duplicate bidder
        open_auction();
        send_bid(1, 4, 1'b0);
        chk("dup_err_first", int'(dup_err), 0);
        send_bid(1, 12, 1'b0);
        chk("dup_err_pulse", int'(dup_err), 1);
        tick();
        chk("dup_err_clear", int'(dup_err), 0);
        do_close();
        tick();
        check_result("dup", 1, 4, SECOND_PRICE ? 0 : 4, 0);
        handshake("dup");

        // Bid and close in the same cycle
        open_auction();
        send_bid(3, 2, 1'b0);
        send_bid(0, 8, 1'b1);
        chk("bidclose_bid_ready", int'(bid_ready), 0);
        tick();
        check_result("bidclose", 0, 8, SECOND_PRICE ? 2 : 8, 0);
        handshake("bidclose");

        // Reset mid-collection discards bids
        open_auction();
        send_bid(0, 15, 1'b0);
        send_bid(1, 14, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_bid_ready", int'(bid_ready), 0);
        chk("midrst_winner", int'(winner), 0);
        chk("midrst_bid", int'(winning_bid), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_result", int'(result_valid), 0);
        end
        open_auction();
        send_bid(2, 3, 1'b0);
        do_close();
        tick();
        check_result("after_rst", 2, 3, SECOND_PRICE ? 0 : 3, 0);
        handshake("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/auction_seq.md
AUCTION_SEQ -- requirements
Module: auction_seq

Interface
REQ-001 The block SHALL have parameter N, default 2, where log2 of bidder count gives 2**N bidders.
REQ-002 The block SHALL have parameter W, default 2, which is the bid width in bits (unsigned).
REQ-003 The block SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  opens a new auction (IDLE only).
REQ-006 The block SHALL have port bid_valid  input  1  bid offered.
REQ-007 The block SHALL have port bid_ready  output  1  bid accepted when high with bid_valid.
REQ-008 The block SHALL have port bid_id  input  N  bidder index.
REQ-009 The block SHALL have port bid_value  input  W  bid amount.
REQ-010 The block SHALL have port close  input  1  ends bid collection.
REQ-011 The block SHALL have port result_valid  output  1  result outputs valid.
REQ-012 The block SHALL have port result_ready  input  1  consumer accepts result.
REQ-013 The block SHALL have port winner  output  N  winning bidder index.
REQ-014 The block SHALL have port winning_bid  output  W  highest bid.
REQ-015 The block SHALL have port price  output  W  clearing price.
REQ-016 The block SHALL have port no_bids  output  1  auction closed with zero accepted bids.
REQ-017 The block SHALL have port dup_err  output  1  one-cycle pulse: repeat bid from same bidder.

Function
REQ-018 The FSM SHALL have states IDLE, COLLECT, RESOLVE, RESULT; IDLE->COLLECT on start; COLLECT->RESOLVE on close or all bidders seen; RESOLVE->RESULT unconditionally; RESULT->IDLE on result_ready.
REQ-019 bid_ready SHALL be 1 exactly in COLLECT; start SHALL be ignored outside IDLE.
REQ-020 Entering COLLECT SHALL clear the seen mask (2**N bits), running max, leader index and have_bid flag.
REQ-021 An accepted bid with seen[bid_id]=0 SHALL set seen[bid_id] and, if have_bid=0 or bid_value > max (strict), load max/leader; ties keep the earlier-accepted bid.
REQ-022 An accepted bid with seen[bid_id]=1 SHALL not alter max/leader and SHALL pulse dup_err for one cycle the following cycle.
REQ-023 When the bid accepted completes the seen mask (all ones), the FSM SHALL move to RESOLVE the next cycle without close.
REQ-024 close asserted with an accepted bid in the same cycle SHALL accept and evaluate the bid first, then leave COLLECT.
REQ-025 In RESOLVE the block SHALL register winner, winning_bid, price, no_bids; result_valid SHALL rise the next cycle (close at cycle t -> result_valid at t+2).
REQ-026 If no bid was accepted, outputs SHALL be winner=0, winning_bid=0, price=0, no_bids=1.
REQ-027 In RESULT outputs SHALL hold stable until result_valid && result_ready; result_valid SHALL drop the next cycle; a start in that handshake cycle SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE and zero seen mask, max, leader and every output (bid_ready, result_valid, winner, winning_bid, price, no_bids, dup_err = 0).
REQ-029 rst mid-auction SHALL discard all collected bids; no result SHALL be produced for that auction.

Configuration
REQ-030 With macro AUCTION_SECOND_PRICE_EN defined, the block SHALL track the second-highest distinct-bidder bid (a displaced leader becomes second; a bid equal to max updates second) and price SHALL equal it (0 if one bid).
REQ-031 Without AUCTION_SECOND_PRICE_EN, no second-price storage SHALL be built and price SHALL equal winning_bid.

Structure
REQ-032 Package auction_pkg SHALL hold the FSM state typedef and the bidder-count localparam (2**N helper function).
REQ-033 The compare-and-update slice (max, leader, optional second) SHALL be sub-module auction_max_update, instantiated once.

Verification (N=2, W=4)
REQ-034 Bids id0=5, id1=9, id2=3, id3=7, no close -> auto-close; winner=1, winning_bid=9, price=9 (7 with AUCTION_SECOND_PRICE_EN), no_bids=0.
REQ-035 Bids id2=6 then id0=6, then close -> winner=2 (tie keeps first), winning_bid=6, price 6 both builds.
REQ-036 start then close, no bids -> result_valid at close+2, winner=0, winning_bid=0, price=0, no_bids=1.
REQ-037 Bid id1=4, then id1=12 -> dup_err pulse one cycle; after close winner=1, winning_bid=4.
REQ-038 result_ready held 0 for 5 cycles -> outputs stable; rst asserted in COLLECT after 2 bids -> bid_ready=0, no result_valid; next auction is unaffected by the discarded bids.
